// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: local byte-lane RAM plus stalling MMIO bridge
// I/O accesses hold the core via cpu_en until the external bus answers or the timer aborts.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [15:0] MMIO_TAG   = 16'hFFFF,
  parameter int          TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_write_en,
  input  logic        mem_read_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        cpu_en,
  output logic        io_req_valid,
  input  logic        io_req_ready,
  output logic        io_req_we,
  output logic [3:0]  io_req_be,
  output logic [31:0] io_req_addr,
  output logic [31:0] io_req_wdata,
  input  logic        io_rsp_valid,
  input  logic [31:0] io_rsp_rdata,
  output logic        io_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_timer;
  logic [31:0]           r_ram [2**ADDR_WIDTH];
  logic [31:0]           r_ram_q;
  logic [31:0]           r_io_rdata;
  logic                  r_src_io;
  logic                  r_io_err;
  logic                  w_acc;
  logic                  w_io_hit;
  logic                  w_io_acc;
  logic                  w_io_we;
  logic                  w_busy;
  logic                  w_abort;
  logic                  w_cpu_en;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_acc    = mem_read_en | (|mem_write_en);
  assign w_io_hit = (mem_addr[31:16] == MMIO_TAG);
  assign w_io_acc = w_acc & w_io_hit;
  assign w_io_we  = |mem_write_en;
  assign w_idx    = mem_addr[ADDR_WIDTH+1:2];
  assign w_busy   = (r_state == S_REQ) || (r_state == S_RSP);
  assign w_abort  = w_busy && (r_timer == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // DONE releases the core for exactly one edge and never re-detects the held request.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cpu_en = ~w_io_acc;
        if (w_io_acc) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_abort)           w_state_nxt = S_DONE;
        else if (io_req_ready) w_state_nxt = w_io_we ? S_DONE : S_RSP;
      end
      S_RSP: begin
        if (w_abort || io_rsp_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_cpu_en    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) w_cpu_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_timer <= 8'd0;
    else if (w_busy) r_timer <= r_timer + 8'd1;
    else             r_timer <= 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_rdata <= 32'd0;
      r_io_err   <= 1'b0;
    end else if (w_abort) begin
      r_io_rdata <= 32'hDEADBEEF;
      r_io_err   <= 1'b1;
    end else if ((r_state == S_RSP) && io_rsp_valid) begin
      r_io_rdata <= io_rsp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_src_io <= 1'b0;
    else if (w_cpu_en) r_src_io <= w_io_acc;
  end

  // I/O-window addresses alias into the RAM index, so they must not write it.
  always_ff @(posedge clk) begin
    if (w_cpu_en && !w_io_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_en[i]) r_ram[w_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_ram_q <= 32'd0;
    else if (w_cpu_en && mem_read_en) r_ram_q <= r_ram[w_idx];
  end

  assign mem_read_data = r_src_io ? r_io_rdata : r_ram_q;
  assign cpu_en        = w_cpu_en;
  assign io_req_valid  = (r_state == S_REQ);
  assign io_req_we     = w_io_we;
  assign io_req_be     = w_io_we ? mem_write_en : 4'b1111;
  assign io_req_addr   = mem_addr;
  assign io_req_wdata  = mem_write_data;
  assign io_err        = r_io_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
// Reads push expected data when driven; the value is popped and compared once the core would sample it.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mem_write_en = 4'd0;
  logic        mem_read_en = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_write_data = 32'd0;
  logic [31:0] mem_read_data;
  logic        cpu_en;
  logic        io_req_valid;
  logic        io_req_ready = 1'b0;
  logic        io_req_we;
  logic [3:0]  io_req_be;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic        io_rsp_valid = 1'b0;
  logic [31:0] io_rsp_rdata = 32'd0;
  logic        io_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [1024];
  logic [31:0] sb_q [$];

  int          cfg_req_n = 1;
  int          cfg_rsp_m = 1;
  logic        cfg_never = 1'b0;
  logic [31:0] cfg_rdata = 32'd0;
  logic        in_rsp = 1'b0;
  int          req_cnt = 0;
  int          rsp_cnt = 0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_be = 4'd0;
  logic [31:0] cap_addr = 32'd0;

  dmem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .mem_write_en  (mem_write_en),
    .mem_read_en   (mem_read_en),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .cpu_en        (cpu_en),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_we     (io_req_we),
    .io_req_be     (io_req_be),
    .io_req_addr   (io_req_addr),
    .io_req_wdata  (io_req_wdata),
    .io_rsp_valid  (io_rsp_valid),
    .io_rsp_rdata  (io_rsp_rdata),
    .io_err        (io_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // External bus: ready on the cfg_req_n-th REQ cycle, response on the cfg_rsp_m-th RSP cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        io_req_ready = 1'b0;
        io_rsp_valid = 1'b0;
        in_rsp       = 1'b0;
        req_cnt      = 0;
        rsp_cnt      = 0;
      end else begin
        if (io_rsp_valid) begin
          io_rsp_valid = 1'b0;
          in_rsp       = 1'b0;
        end
        if (io_req_ready) begin
          io_req_ready = 1'b0;
          req_cnt      = 0;
          if (!io_req_we) begin
            in_rsp  = 1'b1;
            rsp_cnt = 0;
          end
        end
        if (in_rsp) begin
          rsp_cnt++;
          if (rsp_cnt == cfg_rsp_m) begin
            io_rsp_valid = 1'b1;
            io_rsp_rdata = cfg_rdata;
          end
        end else if (io_req_valid) begin
          req_cnt++;
          if (!cfg_never && req_cnt == cfg_req_n) begin
            io_req_ready = 1'b1;
            cap_we       = io_req_we;
            cap_be       = io_req_be;
            cap_addr     = io_req_addr;
          end
        end else begin
          req_cnt = 0;
        end
      end
    end
  end

  task automatic access(input logic [3:0] we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, output int low);
    logic [31:0] exp;
    @(posedge clk);
    #1;
    mem_write_en   = we;
    mem_read_en    = re;
    mem_addr       = addr;
    mem_write_data = wd;
    if (re) begin
      if (addr[31:16] == 16'hFFFF) exp = cfg_never ? 32'hDEADBEEF : cfg_rdata;
      else                         exp = model[addr[11:2]];
      sb_q.push_back(exp);
    end
    low = 0;
    @(negedge clk);
    while (!cpu_en && low < 300) begin
      low++;
      @(negedge clk);
    end
    if (low >= 300) check("stall_bound", 32'(low), 32'd0);
    @(posedge clk);
    #1;
    mem_write_en = 4'd0;
    mem_read_en  = 1'b0;
    if (addr[31:16] != 16'hFFFF) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) model[addr[11:2]][8*i +: 8] = wd[8*i +: 8];
      end
    end
    @(negedge clk);
    if (re) check("rdata", mem_read_data, sb_q.pop_front());
  endtask

  initial begin
    int low;
    int w;
    logic [31:0] a;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    check("rst_req_valid", {31'd0, io_req_valid}, 32'd0);
    check("rst_io_err", {31'd0, io_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    access(4'b1111, 1'b0, 32'h0000_0010, 32'h11223344, low);
    check("sw_no_stall", 32'(low), 32'd0);
    access(4'b0000, 1'b1, 32'h0000_0011, 32'd0, low);
    check("lb_no_stall", 32'(low), 32'd0);
    access(4'b0010, 1'b0, 32'h0000_0010, 32'hAAAAAAAA, low);
    access(4'b0000, 1'b1, 32'h0000_0010, 32'd0, low);
    check("lane_model", model[4], 32'h1122AA44);

    access(4'b1111, 1'b0, 32'h0000_0000, 32'h5A5A1234, low);
    access(4'b0000, 1'b1, 32'h0000_1000, 32'd0, low);

    for (int k = 0; k < 8; k++) begin
      a = $urandom & 32'h7FFF_FFFC;
      d = $urandom;
      access(4'b1111, 1'b0, a, d, low);
      access(4'($urandom_range(1, 15)), 1'b0, a, $urandom, low);
      access(4'b0000, 1'b1, a | 32'(k & 3), 32'd0, low);
    end

    access(4'b1111, 1'b0, 32'h0000_0020, 32'h0BADF00D, low);

    cfg_never = 1'b0;
    cfg_req_n = 2;
    cfg_rsp_m = 3;
    cfg_rdata = 32'hCAFEF00D;
    access(4'b0000, 1'b1, 32'hFFFF_0004, 32'd0, low);
    check("io_rd_stall", 32'(low), 32'(1 + cfg_req_n + cfg_rsp_m));
    check("io_rd_we", {31'd0, cap_we}, 32'd0);
    check("io_rd_be", {28'd0, cap_be}, 32'hF);
    check("io_rd_addr", cap_addr, 32'hFFFF_0004);
    check("io_err_ok", {31'd0, io_err}, 32'd0);

    cfg_req_n = 1;
    access(4'b0001, 1'b0, 32'hFFFF_0003, 32'h77777777, low);
    check("io_wr_stall", 32'(low), 32'd2);
    check("io_wr_we", {31'd0, cap_we}, 32'd1);
    check("io_wr_be", {28'd0, cap_be}, 32'h1);
    check("io_wr_addr", cap_addr, 32'hFFFF_0003);

    cfg_never = 1'b1;
    access(4'b0000, 1'b1, 32'hFFFF_0008, 32'd0, low);
    check("timeout_stall", 32'(low), 32'd65);
    check("timeout_err", {31'd0, io_err}, 32'd1);
    access(4'b0000, 1'b1, 32'h0000_0010, 32'd0, low);
    check("err_sticky", {31'd0, io_err}, 32'd1);

    cfg_never = 1'b0;
    cfg_req_n = 1;
    cfg_rsp_m = 100;
    @(posedge clk);
    #1;
    mem_read_en = 1'b1;
    mem_addr    = 32'hFFFF_000C;
    w = 0;
    while (!in_rsp && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rsp_reached", {31'd0, in_rsp}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, io_req_valid}, 32'd0);
    check("rst_mid_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    mem_read_en = 1'b0;
    mem_addr    = 32'd0;
    @(negedge clk);
    check("rst_err_clear", {31'd0, io_err}, 32'd0);
    access(4'b0000, 1'b1, 32'h0000_0020, 32'd0, low);
    check("post_rst_no_stall", 32'(low), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
